// File: rtl/encoder_sample_sched.sv
// encoder_sample_sched: x4 quadrature decode of N_ENC encoders, windowed snapshots, serial readout
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   enable_i       1 = measurement windows run; 0 = time base and counts held cleared
//   enc_a_i/b_i    raw encoder phases, one bit per channel (asynchronous to clk_i)
//   snap_valid_o   snapshot word available
//   snap_ready_i   consumer accepts the word when valid & ready
//   snap_chan_o    channel index of the current word
//   snap_data_o    OFFSET + signed window count of that channel, modulo 2^W
//   overrun_o      sticky: a window ended while the readout was still busy
//   illegal_o      sticky: A and B of some channel changed in the same sampled cycle
//   flags_clr_i    one-cycle pulse clearing overrun_o and illegal_o (a new event wins)
module encoder_sample_sched #(
    parameter int          N_ENC  = 2,
    parameter int          W      = 32,
    parameter int          PERIOD = 1_000_000,
    parameter int unsigned OFFSET = 32'h3FF
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             enable_i,
    input  logic [N_ENC-1:0] enc_a_i,
    input  logic [N_ENC-1:0] enc_b_i,
    output logic             snap_valid_o,
    input  logic             snap_ready_i,
    output logic [2:0]       snap_chan_o,
    output logic [W-1:0]     snap_data_o,
    output logic             overrun_o,
    output logic             illegal_o,
    input  logic             flags_clr_i
);
    localparam int TW = $clog2(PERIOD);

    typedef enum logic {IDLE, SEND} state_e;

    logic [N_ENC-1:0] a_s1_q, a_s2_q, a_p_q;
    logic [N_ENC-1:0] b_s1_q, b_s2_q, b_p_q;
    logic [N_ENC-1:0] bad;
    logic [1:0]       dpos     [N_ENC];
    logic [W-1:0]     delta    [N_ENC];
    logic [W-1:0]     cnt_q    [N_ENC];
    logic [W-1:0]     cnt_d    [N_ENC];
    logic [W-1:0]     shadow_q [N_ENC];
    logic [W-1:0]     shadow_d [N_ENC];
    logic [W-1:0]     sel;
    logic [TW-1:0]    tcnt_q, tcnt_d;
    logic             tick, accept, last;
    logic             overrun_q, overrun_d, illegal_q, illegal_d;
    logic [2:0]       idx_q, idx_d;
    state_e           state_q, state_d;

    // Two synchroniser flops per pin, then one register holding the previous sampled {A,B}.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            a_s1_q <= '0;
            a_s2_q <= '0;
            a_p_q  <= '0;
            b_s1_q <= '0;
            b_s2_q <= '0;
            b_p_q  <= '0;
        end else begin
            a_s1_q <= enc_a_i;
            a_s2_q <= a_s1_q;
            a_p_q  <= a_s2_q;
            b_s1_q <= enc_b_i;
            b_s2_q <= b_s1_q;
            b_p_q  <= b_s2_q;
        end
    end

    // {B, A^B} turns the Gray sequence 00,10,11,01 into positions 0..3, so the
    // position difference mod 4 gives +1 (forward), 3 (reverse) or 2 (both bits flipped).
    always_comb begin
        for (int i = 0; i < N_ENC; i++) begin
            dpos[i]  = {b_s2_q[i], a_s2_q[i] ^ b_s2_q[i]} - {b_p_q[i], a_p_q[i] ^ b_p_q[i]};
            delta[i] = (dpos[i] == 2'd1) ? W'(1) : (dpos[i] == 2'd3) ? {W{1'b1}} : '0;
            bad[i]   = (dpos[i] == 2'd2);
        end
    end

    assign tick   = enable_i && (tcnt_q == TW'(PERIOD - 1));
    assign tcnt_d = (!enable_i || tick) ? '0 : tcnt_q + TW'(1);

    // The delta decoded in the tick cycle still belongs to the ending window.
    // Shadows are only refreshed when the previous readout has finished.
    always_comb begin
        for (int i = 0; i < N_ENC; i++) begin
            cnt_d[i]    = (!enable_i || tick) ? '0 : cnt_q[i] + delta[i];
            shadow_d[i] = (tick && state_q == IDLE) ? cnt_q[i] + delta[i] : shadow_q[i];
        end
    end

    assign overrun_d = (tick && state_q == SEND) || (overrun_q && !flags_clr_i);
    assign illegal_d = (|bad) || (illegal_q && !flags_clr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tcnt_q    <= '0;
            overrun_q <= 1'b0;
            illegal_q <= 1'b0;
            for (int i = 0; i < N_ENC; i++) begin
                cnt_q[i]    <= '0;
                shadow_q[i] <= '0;
            end
        end else begin
            tcnt_q    <= tcnt_d;
            overrun_q <= overrun_d;
            illegal_q <= illegal_d;
            for (int i = 0; i < N_ENC; i++) begin
                cnt_q[i]    <= cnt_d[i];
                shadow_q[i] <= shadow_d[i];
            end
        end
    end

    // Readout FSM: state register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Readout FSM: next state
    assign accept = (state_q == SEND) && snap_ready_i;
    assign last   = (idx_q == 3'(N_ENC - 1));

    always_comb begin
        state_d = (state_q == IDLE) ? (tick ? SEND : IDLE) : ((accept && last) ? IDLE : SEND);
        idx_d   = (state_q == IDLE) ? '0 : accept ? (last ? '0 : idx_q + 3'd1) : idx_q;
    end

    // Readout FSM: outputs
    always_comb begin
        sel = '0;
        for (int i = 0; i < N_ENC; i++) begin
            if (idx_q == 3'(i)) sel = shadow_q[i];
        end
        snap_valid_o = (state_q == SEND);
        snap_chan_o  = (state_q == SEND) ? idx_q : '0;
        snap_data_o  = (state_q == SEND) ? W'(OFFSET) + sel : '0;
    end

    assign overrun_o = overrun_q;
    assign illegal_o = illegal_q;

endmodule
